// File: rtl/axi_sram_slave_pkg.sv
// Shared AXI constants, burst type and FSM state encodings
// for the cache-side SRAM slave model.
package axi_sram_slave_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [2:0] AXI_SIZE_1B = 3'd0;
    localparam logic [2:0] AXI_SIZE_2B = 3'd1;
    localparam logic [2:0] AXI_SIZE_4B = 3'd2;

    localparam logic [1:0] AXI_BURST_FIXED = 2'd0;
    localparam logic [1:0] AXI_BURST_INCR  = 2'd1;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'd2;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } axi_burst_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_WAIT  = 2'd1,
        R_BURST = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    // Only FIXED holds the address; WRAP and reserved walk like INCR.
    function automatic axi_burst_t burst_norm(input logic [1:0] b);
        return (b == AXI_BURST_FIXED) ? BURST_FIXED : BURST_INCR;
    endfunction

endpackage

// File: rtl/axi_sram_slave_if.sv
// Read (AR/R) and write (AW/W/B) channel bundles between the
// data cache master and the SRAM slave.
interface axi_read_if;
    import axi_sram_slave_pkg::*;

    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  rlast;
    logic                  rready;

    modport slave (
        input  araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rdata, rvalid, rlast
    );

    modport master (
        output araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rdata, rvalid, rlast
    );
endinterface

interface axi_write_if;
    import axi_sram_slave_pkg::*;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic                  bvalid;
    logic                  bready;

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        output awready, wready, bvalid
    );

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        input  awready, wready, bvalid
    );
endinterface

// File: rtl/axi_sram_slave_addr_gen.sv
// Per-beat word index stepper for one AXI channel: next index
// and whether the current beat is the final one of the burst.
module axi_burst_addr_gen
    import axi_sram_slave_pkg::*;
#(
    parameter int IDX_W = 12
) (
    input  logic [IDX_W-1:0] idx,
    input  logic [7:0]       len,
    input  logic [7:0]       cnt,
    input  axi_burst_t       burst,
    output logic [IDX_W-1:0] next_idx,
    output logic             last
);

    // Index wraps naturally at the array size through the width.
    always_comb begin
        next_idx = (burst == BURST_FIXED) ? idx : idx + IDX_W'(1);
        last     = (cnt == len);
    end

endmodule

// File: rtl/axi_sram_slave.sv
// SRAM model serving cache refills (AR/R) and write-backs
// (AW/W/B) concurrently over one shared word array.
module axi_sram_slave
    import axi_sram_slave_pkg::*;
#(
    parameter int    MEM_DEPTH_WORDS = 4096,
    parameter int    READ_LATENCY    = 2,
    parameter string INIT_FILE       = ""
) (
    input  logic       clk,
    input  logic       rst_n,
    axi_read_if.slave  axi_read_if,
    axi_write_if.slave axi_write_if,
    output logic       proto_err
);

    localparam int IW    = $clog2(MEM_DEPTH_WORDS);
    localparam int LAT_W = 4;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH_WORDS];

    // ---------------- read channel ----------------
    rd_state_t             rd_state;
    rd_state_t             rd_next;
    logic [IW-1:0]         r_idx;
    logic [IW-1:0]         r_next_idx;
    logic [7:0]            r_len;
    logic [7:0]            r_cnt;
    axi_burst_t            r_burst;
    logic [LAT_W-1:0]      r_wait;
    logic                  r_last;
    logic                  arready_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  ar_hs;
    logic                  r_hs;
    logic                  r_valid;
    logic                  r_load;

    axi_burst_addr_gen #(.IDX_W(IW)) u_rd_gen (
        .idx      (r_idx),
        .len      (r_len),
        .cnt      (r_cnt),
        .burst    (r_burst),
        .next_idx (r_next_idx),
        .last     (r_last)
    );

    // Read FSM next state and handshake decode.
    always_comb begin
        rd_next = rd_state;
        ar_hs   = 1'b0;
        r_hs    = 1'b0;
        r_valid = 1'b0;
        r_load  = 1'b0;
        unique case (rd_state)
            R_IDLE: begin
                ar_hs = axi_read_if.arvalid && arready_q;
                if (ar_hs) rd_next = R_WAIT;
            end
            R_WAIT: begin
                if (r_wait == '0) begin
                    rd_next = R_BURST;
                    r_load  = 1'b1;
                end
            end
            R_BURST: begin
                r_valid = 1'b1;
                r_hs    = axi_read_if.rready;
                if (r_hs && r_last) rd_next = R_IDLE;
            end
            default: rd_next = R_IDLE;
        endcase
    end

    // Read FSM state, burst context and latency countdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state  <= R_IDLE;
            arready_q <= 1'b0;
            r_idx     <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_burst   <= BURST_INCR;
            r_wait    <= '0;
        end else begin
            rd_state  <= rd_next;
            arready_q <= (rd_next == R_IDLE);
            if (ar_hs) begin
                r_idx   <= axi_read_if.araddr[IW+1:2];
                r_len   <= axi_read_if.arlen;
                r_burst <= burst_norm(axi_read_if.arburst);
                r_cnt   <= '0;
                r_wait  <= LAT_W'(READ_LATENCY - 1);
            end else if (rd_state == R_WAIT && r_wait != '0) begin
                r_wait <= r_wait - LAT_W'(1);
            end
            if (r_hs && !r_last) begin
                r_idx <= r_next_idx;
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    // Registered read data: sampled before same-edge writes land,
    // and held steady while the master stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (r_load) begin
            rdata_q <= mem[r_idx];
        end else if (r_hs) begin
            rdata_q <= r_last ? '0 : mem[r_next_idx];
        end
    end

    assign axi_read_if.arready = arready_q;
    assign axi_read_if.rvalid  = r_valid;
    assign axi_read_if.rlast   = r_valid && r_last;
    assign axi_read_if.rdata   = rdata_q;

    // ---------------- write channel ----------------
    wr_state_t     wr_state;
    wr_state_t     wr_next;
    logic [IW-1:0] w_idx;
    logic [IW-1:0] w_next_idx;
    logic [7:0]    w_len;
    logic [7:0]    w_cnt;
    axi_burst_t    w_burst;
    logic          w_last;
    logic          awready_q;
    logic          aw_hs;
    logic          w_beat;
    logic          w_end;
    logic          perr_set;
    logic          w_ready;
    logic          b_valid;

    axi_burst_addr_gen #(.IDX_W(IW)) u_wr_gen (
        .idx      (w_idx),
        .len      (w_len),
        .cnt      (w_cnt),
        .burst    (w_burst),
        .next_idx (w_next_idx),
        .last     (w_last)
    );

    // Write FSM next state, beat termination and mismatch detect.
    always_comb begin
        wr_next  = wr_state;
        aw_hs    = 1'b0;
        w_beat   = 1'b0;
        w_end    = 1'b0;
        perr_set = 1'b0;
        w_ready  = 1'b0;
        b_valid  = 1'b0;
        unique case (wr_state)
            W_IDLE: begin
                aw_hs = axi_write_if.awvalid && awready_q;
                if (aw_hs) wr_next = W_DATA;
            end
            W_DATA: begin
                w_ready  = 1'b1;
                w_beat   = axi_write_if.wvalid;
                w_end    = w_beat && (axi_write_if.wlast || w_last);
                perr_set = w_end && (axi_write_if.wlast != w_last);
                if (w_end) wr_next = W_RESP;
            end
            W_RESP: begin
                b_valid = 1'b1;
                if (axi_write_if.bready) wr_next = W_IDLE;
            end
            default: wr_next = W_IDLE;
        endcase
    end

    // Write FSM state, burst context and error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state  <= W_IDLE;
            awready_q <= 1'b0;
            w_idx     <= '0;
            w_len     <= '0;
            w_cnt     <= '0;
            w_burst   <= BURST_INCR;
            proto_err <= 1'b0;
        end else begin
            wr_state  <= wr_next;
            awready_q <= (wr_next == W_IDLE);
            proto_err <= perr_set;
            if (aw_hs) begin
                w_idx   <= axi_write_if.awaddr[IW+1:2];
                w_len   <= axi_write_if.awlen;
                w_burst <= burst_norm(axi_write_if.awburst);
                w_cnt   <= '0;
            end else if (w_beat && !w_end) begin
                w_idx <= w_next_idx;
                w_cnt <= w_cnt + 8'd1;
            end
        end
    end

    // Byte-lane merge into the array on each accepted beat.
    always_ff @(posedge clk) begin
        if (w_beat) begin
            for (int k = 0; k < STRB_WIDTH; k++) begin
                if (axi_write_if.wstrb[k])
                    mem[w_idx][8*k +: 8] <= axi_write_if.wdata[8*k +: 8];
            end
        end
    end

    assign axi_write_if.awready = awready_q;
    assign axi_write_if.wready  = w_ready;
    assign axi_write_if.bvalid  = b_valid;

    // Sub-word address bits, upper address bits and size are ignored.
    logic unused_bits;
    assign unused_bits = ^{axi_read_if.araddr[ADDR_WIDTH-1:IW+2],
                           axi_read_if.araddr[1:0],
                           axi_read_if.arsize,
                           axi_write_if.awaddr[ADDR_WIDTH-1:IW+2],
                           axi_write_if.awaddr[1:0],
                           axi_write_if.awsize};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: vector table of write
// and read bursts against a word model plus corner sequences.
`timescale 1ns/1ps
module tb_axi_sram_slave;
    import axi_sram_slave_pkg::*;

    localparam int DEPTH = 4096;
    localparam int RL    = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic proto_err;

    always #5 clk = ~clk;

    axi_read_if  rd_if ();
    axi_write_if wr_if ();

    axi_sram_slave #(
        .MEM_DEPTH_WORDS (DEPTH),
        .READ_LATENCY    (RL),
        .INIT_FILE       ("")
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .axi_read_if  (rd_if),
        .axi_write_if (wr_if),
        .proto_err    (proto_err)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        int          len;
        logic [1:0]  burst;
        logic [31:0] base;
        logic [3:0]  strb;
        int          last_at;
        int          exp_perr;
        bit          tog;
    } vec_t;

    vec_t        vecs [17];
    logic [31:0] model [DEPTH];
    logic [31:0] sb [$];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a, input logic [1:0] b,
                                input int i);
        return (int'(a >> 2) + ((b == 2'd0) ? 0 : i)) & (DEPTH - 1);
    endfunction

    task automatic push_model(input logic [31:0] a, input int len,
                              input logic [1:0] b);
        for (int i = 0; i <= len; i++) sb.push_back(model[widx(a, b, i)]);
    endtask

    task automatic do_write(input vec_t v);
        int nb, n, perr, stall, ix;
        logic [31:0] d;
        nb = ((v.last_at < v.len) ? v.last_at : v.len) + 1;
        @(negedge clk);
        wr_if.awaddr  = v.addr;
        wr_if.awlen   = 8'(v.len);
        wr_if.awburst = v.burst;
        wr_if.awsize  = AXI_SIZE_4B;
        wr_if.awvalid = 1'b1;
        n = 0;
        while (!wr_if.awready && n < 50) begin @(negedge clk); n++; end
        chk("aw_accept", 32'(n < 50), 1);
        @(negedge clk);
        wr_if.awvalid = 1'b0;
        perr = 0;
        stall = 0;
        for (int i = 0; i < nb; i++) begin
            d = v.base + 32'(i);
            wr_if.wvalid = 1'b1;
            wr_if.wdata  = d;
            wr_if.wstrb  = v.strb;
            wr_if.wlast  = (i == v.last_at);
            n = 0;
            while (!wr_if.wready && n < 20) begin
                stall++;
                @(negedge clk);
                n++;
            end
            ix = widx(v.addr, v.burst, i);
            for (int k = 0; k < 4; k++)
                if (v.strb[k]) model[ix][8*k +: 8] = d[8*k +: 8];
            @(negedge clk);
            if (proto_err) perr++;
        end
        wr_if.wvalid = 1'b0;
        wr_if.wlast  = 1'b0;
        wr_if.bready = 1'b1;
        n = 0;
        while (!wr_if.bvalid && n < 50) begin
            @(negedge clk);
            if (proto_err) perr++;
            n++;
        end
        chk("b_valid", 32'(wr_if.bvalid), 1);
        @(negedge clk);
        wr_if.bready = 1'b0;
        chk("b_drop", 32'(wr_if.bvalid), 0);
        chk("perr_clear", 32'(proto_err), 0);
        chk("perr_count", perr, v.exp_perr);
        chk("w_stall", stall, 0);
    endtask

    task automatic run_read(input logic [31:0] a, input int len,
                            input logic [1:0] b, input bit tog);
        int n, lat, beats, gaps, cyc;
        bit pat, held;
        logic [31:0] hd, e;
        logic hl;
        @(negedge clk);
        rd_if.araddr  = a;
        rd_if.arlen   = 8'(len);
        rd_if.arburst = b;
        rd_if.arsize  = AXI_SIZE_4B;
        rd_if.arvalid = 1'b1;
        rd_if.rready  = 1'b0;
        n = 0;
        while (!rd_if.arready && n < 50) begin @(negedge clk); n++; end
        chk("ar_accept", 32'(n < 50), 1);
        @(negedge clk);
        rd_if.arvalid = 1'b0;
        lat = 1;
        while (!rd_if.rvalid && lat < 50) begin @(negedge clk); lat++; end
        if (!tog) chk("r_latency", lat, RL + 1);
        beats = 0;
        gaps  = 0;
        cyc   = 0;
        pat   = 1'b1;
        while (beats <= len && cyc < 300) begin
            rd_if.rready = tog ? pat : 1'b1;
            if (rd_if.rvalid && rd_if.rready) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("rdata", rd_if.rdata, e);
                end
                chk("rlast", 32'(rd_if.rlast), 32'(beats == len));
                beats++;
            end else if (!rd_if.rvalid) begin
                gaps++;
            end
            held = rd_if.rvalid && !rd_if.rready;
            hd   = rd_if.rdata;
            hl   = rd_if.rlast;
            @(negedge clk);
            cyc++;
            pat = !pat;
            if (held) begin
                chk("r_hold_data", rd_if.rdata, hd);
                chk("r_hold_last", 32'(rd_if.rlast), 32'(hl));
            end
        end
        rd_if.rready = 1'b0;
        chk("r_beats", beats, len + 1);
        if (!tog) chk("r_gaps", gaps, 0);
        chk("r_idle", 32'(rd_if.rvalid), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        rst_n = 1'b0;
        rd_if.araddr = '0; rd_if.arlen = '0; rd_if.arsize = '0;
        rd_if.arburst = '0; rd_if.arvalid = 1'b0; rd_if.rready = 1'b0;
        wr_if.awaddr = '0; wr_if.awlen = '0; wr_if.awsize = '0;
        wr_if.awburst = '0; wr_if.awvalid = 1'b0; wr_if.wdata = '0;
        wr_if.wstrb = '0; wr_if.wlast = 1'b0; wr_if.wvalid = 1'b0;
        wr_if.bready = 1'b0;

        vecs[0]  = '{1, 32'h100,  7, 2'd1, 32'h000000A0, 4'hF, 7, 0, 0};
        vecs[1]  = '{1, 32'h200,  7, 2'd1, 32'h11110000, 4'hF, 7, 0, 0};
        vecs[2]  = '{1, 32'h204,  0, 2'd1, 32'hDEADBEEF, 4'h5, 0, 0, 0};
        vecs[3]  = '{0, 32'h100,  7, 2'd1, 32'h0,        4'h0, 0, 0, 0};
        vecs[4]  = '{0, 32'h100,  7, 2'd1, 32'h0,        4'h0, 0, 0, 1};
        vecs[5]  = '{0, 32'h200,  7, 2'd1, 32'h0,        4'h0, 0, 0, 0};
        vecs[6]  = '{1, 32'h300,  7, 2'd1, 32'h33000000, 4'hF, 7, 0, 0};
        vecs[7]  = '{1, 32'h300,  7, 2'd1, 32'h55000000, 4'hF, 3, 1, 0};
        vecs[8]  = '{0, 32'h300,  7, 2'd1, 32'h0,        4'h0, 0, 0, 0};
        vecs[9]  = '{1, 32'h400,  3, 2'd0, 32'h77000000, 4'hF, 3, 0, 0};
        vecs[10] = '{0, 32'h400,  0, 2'd1, 32'h0,        4'h0, 0, 0, 0};
        vecs[11] = '{0, 32'h100,  2, 2'd0, 32'h0,        4'h0, 0, 0, 0};
        vecs[12] = '{1, 32'h3FFC, 1, 2'd1, 32'h000000C0, 4'hF, 1, 0, 0};
        vecs[13] = '{0, 32'h3FFC, 1, 2'd1, 32'h0,        4'h0, 0, 0, 0};
        vecs[14] = '{1, 32'h500,  1, 2'd1, 32'h66000000, 4'hF, 5, 1, 0};
        vecs[15] = '{0, 32'h500,  1, 2'd1, 32'h0,        4'h0, 0, 0, 0};
        vecs[16] = '{0, 32'h200,  3, 2'd3, 32'h0,        4'h0, 0, 0, 1};

        repeat (3) @(negedge clk);
        chk("rst_arready", 32'(rd_if.arready), 0);
        chk("rst_rvalid",  32'(rd_if.rvalid), 0);
        chk("rst_rlast",   32'(rd_if.rlast), 0);
        chk("rst_rdata",   rd_if.rdata, 0);
        chk("rst_awready", 32'(wr_if.awready), 0);
        chk("rst_wready",  32'(wr_if.wready), 0);
        chk("rst_bvalid",  32'(wr_if.bvalid), 0);
        chk("rst_perr",    32'(proto_err), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i]);
            end else begin
                push_model(vecs[i].addr, vecs[i].len, vecs[i].burst);
                run_read(vecs[i].addr, vecs[i].len, vecs[i].burst,
                         vecs[i].tog);
            end
        end

        sb.push_back(32'h11AD00EF);
        run_read(32'h204, 0, 2'd1, 1'b0);
        sb.push_back(32'h77000003);
        run_read(32'h400, 0, 2'd1, 1'b0);
        sb.push_back(32'h000000C1);
        run_read(32'h0, 0, 2'd1, 1'b0);

        push_model(32'h100, 7, 2'd1);
        @(negedge clk);
        rd_if.araddr  = 32'h100;
        rd_if.arlen   = 8'd7;
        rd_if.arburst = 2'd1;
        rd_if.arvalid = 1'b1;
        n = 0;
        while (!rd_if.arready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        rd_if.arvalid = 1'b0;
        n = 0;
        while (!rd_if.rvalid && n < 50) begin @(negedge clk); n++; end
        rd_if.rready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            if (rd_if.rvalid && sb.size() != 0)
                chk("mid_rdata", rd_if.rdata, sb.pop_front());
            else
                chk("mid_rvalid", 32'(rd_if.rvalid), 1);
            @(negedge clk);
        end
        chk("mid_beat4_valid", 32'(rd_if.rvalid), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rvalid",  32'(rd_if.rvalid), 0);
        chk("mid_rst_rlast",   32'(rd_if.rlast), 0);
        chk("mid_rst_arready", 32'(rd_if.arready), 0);
        chk("mid_rst_rdata",   rd_if.rdata, 0);
        sb.delete();
        rd_if.rready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (rd_if.rvalid || wr_if.bvalid) n++;
        end
        chk("post_rst_quiet", n, 0);
        push_model(32'h100, 7, 2'd1);
        run_read(32'h100, 7, 2'd1, 1'b0);
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
